uart_transmitter_cfg: RTL and testbench
=======================================

UART_TRANSMITTER_CFG -- requirements
Module: uart_transmitter_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, sets data bits per frame; legal values 5..8.
REQ-002 Parameter PARITY, default 0, selects parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, sets stop bits per frame; legal values 1..2.
REQ-004 Port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port tx_clk_en, input, 1 bit: one-sys_clk-wide baud tick.
REQ-007 Port tx_valid, input, 1 bit: a frame is offered.
REQ-008 Port tx_data, input, 8 bits: frame payload; bits [DATA_BITS-1:0] are used, LSB first.
REQ-009 Port tx_ready, output, 1 bit: block accepts a frame this cycle.
REQ-010 Port uart_tx, output, 1 bit: serial line, idle high.
REQ-011 Port uart_tx_busy, output, 1 bit: a frame is in progress; always equal to the inverse of tx_ready.
REQ-012 Port tx_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-013 FSM states are IDLE, START, DATA, PAR, STOP1, STOP2; any other encoding returns to IDLE with uart_tx=1.
REQ-014 tx_ready is 1 only in IDLE.
- Acceptance: tx_valid=1 while tx_ready=1.
- On the same edge: tx_data[DATA_BITS-1:0] latched into a shift register, bit counter cleared, state moves to START.
REQ-015 tx_valid while busy is ignored; tx_data changes after acceptance do not affect the frame in flight.
REQ-016 START: uart_tx holds 1 until the first tx_clk_en; on that tick uart_tx<=0 and state moves to DATA.
REQ-017 DATA: on each tick, uart_tx<=shift[0], shift right by one, counter increments.
- After the DATA_BITS-th bit, next state is PAR if PARITY!=0, else STOP1.
REQ-018 Parity bit value: even = XOR of the DATA_BITS latched bits; odd = its inverse.
- Computed from the latched copy, not from live tx_data.
REQ-019 PAR: on the tick, uart_tx<=parity bit and state moves to STOP1.
REQ-020 STOP1: on the tick, uart_tx<=1.
- Next state is STOP2 if STOP_BITS==2, else IDLE.
REQ-021 STOP2: on the tick, uart_tx stays 1 and state moves to IDLE.
REQ-022 tx_done=1 for exactly the one sys_clk following the transition into IDLE from STOP1/STOP2; 0 otherwise.
REQ-023 Each frame bit is driven for exactly one tick period.
- A frame accepted on the cycle tx_ready re-asserts starts its start bit on the next tick.
- This gives gapless back-to-back frames.
REQ-024 Without tx_clk_en the FSM state and uart_tx do not change.
REQ-025 tx_valid coinciding with tx_clk_en in IDLE is accepted; the start bit waits for the following tick.

Reset
REQ-026 While sys_rst_n=0, regardless of sys_clk:
- uart_tx=1, state IDLE, tx_ready=1, uart_tx_busy=0, tx_done=0, shift register and counters 0.
REQ-027 Reset mid-frame aborts the frame; the line returns high immediately and no tx_done is issued.
REQ-028 After release, a frame may be accepted on the first sys_clk edge.

Structure
REQ-029 Package uart_pkg holds:
- the state encoding constants;
- the parity-mode constants PARITY_NONE=0, PARITY_EVEN=1, PARITY_ODD=2.
REQ-030 No sub-module; the baud tick is supplied externally by the existing clock-enable generator.
REQ-031 Illegal parameter values are flagged by an elaboration-time check.

Verification
REQ-032 8N1, accept 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1 on successive ticks, then a single tx_done pulse.
REQ-033 DATA_BITS=7, PARITY=1, accept 0x43 -> 0, 1100001, parity 1, stop 1; tx_data bit7 is ignored.
REQ-034 8O2, accept 0x00 -> 0, eight 0s, parity 1, two stop 1s; tx_done follows the second stop tick.
REQ-035 Hold tx_valid=1 with 0x55 then 0xAA -> two frames with no idle tick between them; exactly two tx_done pulses.
REQ-036 Change tx_data and pulse tx_valid mid-frame -> transmitted bits match the originally latched byte; no second acceptance.
REQ-037 Assert sys_rst_n=0 during DATA bit 3 -> uart_tx=1 asynchronously, busy=0, no tx_done; the next frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP1 = 3'd4,
        ST_STOP2 = 3'd5
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Bit counter width; covers up to 8 data bits.
    localparam int CNT_W = 4;

endpackage

// File: rtl/uart_transmitter_cfg.sv
// UART transmitter with compile-time frame format, paced by an external baud tick.
// Each frame bit is launched on a tick and held until the next tick.
module uart_transmitter_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tx_clk_en,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       uart_tx_busy,
    output logic       tx_done
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_transmitter_cfg: illegal DATA_BITS/PARITY/STOP_BITS");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic             PAR_INV  = (PARITY == PARITY_ODD);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 par, par_n;
    logic                 tx_n, done_n;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            shift   <= '0;
            cnt     <= '0;
            par     <= 1'b0;
            uart_tx <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            cnt     <= cnt_n;
            par     <= par_n;
            uart_tx <= tx_n;
            tx_done <= done_n;
        end
    end

    // Parity accumulates from the latched bits as they shift out.
    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = cnt;
        par_n   = par;
        tx_n    = uart_tx;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_n = tx_data[DATA_BITS-1:0];
                    cnt_n   = '0;
                    par_n   = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (tx_clk_en) begin
                    tx_n    = 1'b0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_clk_en) begin
                    tx_n    = shift[0];
                    par_n   = par ^ shift[0];
                    shift_n = shift >> 1;
                    cnt_n   = cnt + 1'b1;
                    if (cnt == LAST_BIT)
                        state_n = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP1;
                end
            end
            ST_PAR: begin
                if (tx_clk_en) begin
                    tx_n    = par ^ PAR_INV;
                    state_n = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (tx_clk_en) begin
                    tx_n = 1'b1;
                    if (STOP_BITS == 2) begin
                        state_n = ST_STOP2;
                    end else begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (tx_clk_en) begin
                    tx_n    = 1'b1;
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign tx_ready     = (state == ST_IDLE);
    assign uart_tx_busy = ~tx_ready;

endmodule

// File: tb/tb_uart_transmitter_cfg.sv
// Directed bench for uart_transmitter_cfg: 8N1, 7E1 and 8O2 instances share clock, reset and tick.
module tb_uart_transmitter_cfg;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       en = 1'b0;
    logic       v [3];
    logic [7:0] d [3];
    logic       line [3];
    logic       ready [3];
    logic       busy [3];
    logic       done [3];

    int pass_cnt = 0;
    int total = 0;

    always #5 sys_clk = ~sys_clk;

    uart_transmitter_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_clk_en(en), .tx_valid(v[0]),
        .tx_data(d[0]), .tx_ready(ready[0]), .uart_tx(line[0]),
        .uart_tx_busy(busy[0]), .tx_done(done[0]));

    uart_transmitter_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7e1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_clk_en(en), .tx_valid(v[1]),
        .tx_data(d[1]), .tx_ready(ready[1]), .uart_tx(line[1]),
        .uart_tx_busy(busy[1]), .tx_done(done[1]));

    uart_transmitter_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8o2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_clk_en(en), .tx_valid(v[2]),
        .tx_data(d[2]), .tx_ready(ready[2]), .uart_tx(line[2]),
        .uart_tx_busy(busy[2]), .tx_done(done[2]));

    // Issues n ticks (two idle cycles after each) and records the line after every tick.
    // Optionally drops tx_valid at tick drop_at, or pokes new data/valid before tick poke_at.
    task automatic run_ticks(input int k, input int n, input int drop_at, input int poke_at,
                             output logic [31:0] bits, output int dones, output int done_at,
                             output int glitches);
        bits = '0;
        dones = 0;
        done_at = -1;
        glitches = 0;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) v[k] = 1'b0;
            if (i == poke_at) begin
                d[k] = 8'hFF;
                v[k] = 1'b1;
                @(negedge sys_clk);
                v[k] = 1'b0;
                if (done[k]) dones++;
            end
            en = 1'b1;
            @(negedge sys_clk);
            en = 1'b0;
            bits[i] = line[k];
            if (done[k]) begin
                dones++;
                done_at = i;
            end
            repeat (2) begin
                @(negedge sys_clk);
                if (line[k] !== bits[i]) glitches++;
                if (done[k]) dones++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            total++; if (line[k] !== 1'b1) $display("FAIL reset_line[%0d]: got %b want 1", k, line[k]); else pass_cnt++;
            total++; if (ready[k] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", k, ready[k]); else pass_cnt++;
            total++; if (busy[k] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); else pass_cnt++;
            total++; if (done[k] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", k, done[k]); else pass_cnt++;
        end
    endtask

    // Release reset and accept 0xA5 on the very first edge.
    task automatic test_8n1();
        logic [31:0] bits;
        int dones, done_at, gl;
        sys_rst_n = 1'b1;
        d[0] = 8'hA5;
        v[0] = 1'b1;
        @(negedge sys_clk);
        v[0] = 1'b0;
        total++; if (busy[0] !== 1'b1) $display("FAIL 8n1_accept_busy: got %b want 1", busy[0]); else pass_cnt++;
        total++; if (line[0] !== 1'b1) $display("FAIL 8n1_start_waits: got %b want 1", line[0]); else pass_cnt++;
        run_ticks(0, 10, -1, -1, bits, dones, done_at, gl);
        total++; if (bits[9:0] !== {1'b1, 8'hA5, 1'b0}) $display("FAIL 8n1_frame: got %b want %b", bits[9:0], {1'b1, 8'hA5, 1'b0}); else pass_cnt++;
        total++; if (dones !== 1) $display("FAIL 8n1_done_count: got %0d want 1", dones); else pass_cnt++;
        total++; if (done_at !== 9) $display("FAIL 8n1_done_at: got %0d want 9", done_at); else pass_cnt++;
        total++; if (gl !== 0) $display("FAIL 8n1_hold_between_ticks: got %0d changes want 0", gl); else pass_cnt++;
        total++; if (ready[0] !== 1'b1) $display("FAIL 8n1_idle_after: got %b want 1", ready[0]); else pass_cnt++;
    endtask

    // 7E1 with bit7 set (ignored); valid coincides with a tick while idle.
    task automatic test_parity_even();
        logic [31:0] bits;
        int dones, done_at, gl;
        d[1] = 8'hC3;
        v[1] = 1'b1;
        en = 1'b1;
        @(negedge sys_clk);
        v[1] = 1'b0;
        en = 1'b0;
        total++; if (busy[1] !== 1'b1) $display("FAIL 7e1_accept_on_tick: got %b want 1", busy[1]); else pass_cnt++;
        total++; if (line[1] !== 1'b1) $display("FAIL 7e1_start_deferred: got %b want 1", line[1]); else pass_cnt++;
        run_ticks(1, 10, -1, -1, bits, dones, done_at, gl);
        total++; if (bits[9:0] !== 10'b1_1_1000011_0) $display("FAIL 7e1_frame: got %b want %b", bits[9:0], 10'b1_1_1000011_0); else pass_cnt++;
        total++; if (dones !== 1) $display("FAIL 7e1_done_count: got %0d want 1", dones); else pass_cnt++;
        total++; if (done_at !== 9) $display("FAIL 7e1_done_at: got %0d want 9", done_at); else pass_cnt++;
    endtask

    task automatic test_parity_odd_2stop();
        logic [31:0] bits;
        int dones, done_at, gl;
        d[2] = 8'h00;
        v[2] = 1'b1;
        @(negedge sys_clk);
        v[2] = 1'b0;
        run_ticks(2, 12, -1, -1, bits, dones, done_at, gl);
        total++; if (bits[11:0] !== 12'b1_1_1_00000000_0) $display("FAIL 8o2_frame: got %b want %b", bits[11:0], 12'b1_1_1_00000000_0); else pass_cnt++;
        total++; if (dones !== 1) $display("FAIL 8o2_done_count: got %0d want 1", dones); else pass_cnt++;
        total++; if (done_at !== 11) $display("FAIL 8o2_done_at: got %0d want 11", done_at); else pass_cnt++;
        total++; if (gl !== 0) $display("FAIL 8o2_hold_between_ticks: got %0d changes want 0", gl); else pass_cnt++;
    endtask

    // Valid held high: 0x55 then 0xAA must run with no idle tick between frames.
    task automatic test_back_to_back();
        logic [31:0] bits;
        int dones, done_at, gl;
        d[0] = 8'h55;
        v[0] = 1'b1;
        @(negedge sys_clk);
        d[0] = 8'hAA;
        run_ticks(0, 20, 10, -1, bits, dones, done_at, gl);
        total++; if (bits[19:0] !== 20'b1_10101010_0_1_01010101_0) $display("FAIL b2b_frames: got %b want %b", bits[19:0], 20'b1_10101010_0_1_01010101_0); else pass_cnt++;
        total++; if (dones !== 2) $display("FAIL b2b_done_count: got %0d want 2", dones); else pass_cnt++;
        total++; if (done_at !== 19) $display("FAIL b2b_last_done_at: got %0d want 19", done_at); else pass_cnt++;
        total++; if (busy[0] !== 1'b0) $display("FAIL b2b_idle_after: got %b want 0", busy[0]); else pass_cnt++;
    endtask

    // New data and a valid pulse mid-frame must not disturb the latched byte.
    task automatic test_midframe();
        logic [31:0] bits;
        int dones, done_at, gl;
        d[0] = 8'h3C;
        v[0] = 1'b1;
        @(negedge sys_clk);
        v[0] = 1'b0;
        run_ticks(0, 10, -1, 3, bits, dones, done_at, gl);
        total++; if (bits[9:0] !== 10'b1_00111100_0) $display("FAIL mid_frame: got %b want %b", bits[9:0], 10'b1_00111100_0); else pass_cnt++;
        total++; if (dones !== 1) $display("FAIL mid_done_count: got %0d want 1", dones); else pass_cnt++;
        total++; if (ready[0] !== 1'b1) $display("FAIL mid_no_second_accept: got %b want 1", ready[0]); else pass_cnt++;
    endtask

    // Reset during data bit 3 of 0xA5 (a 0 bit), then a clean frame after release.
    task automatic test_reset_midframe();
        logic [31:0] bits;
        int dones, done_at, gl;
        d[0] = 8'hA5;
        v[0] = 1'b1;
        @(negedge sys_clk);
        v[0] = 1'b0;
        run_ticks(0, 5, -1, -1, bits, dones, done_at, gl);
        total++; if (bits[4:0] !== 5'b01010) $display("FAIL rst_pre_bits: got %b want 01010", bits[4:0]); else pass_cnt++;
        #2 sys_rst_n = 1'b0;
        #1;
        total++; if (line[0] !== 1'b1) $display("FAIL rst_async_line: got %b want 1", line[0]); else pass_cnt++;
        total++; if (busy[0] !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy[0]); else pass_cnt++;
        @(negedge sys_clk);
        total++; if (done[0] !== 1'b0) $display("FAIL rst_no_done: got %b want 0", done[0]); else pass_cnt++;
        sys_rst_n = 1'b1;
        d[0] = 8'h96;
        v[0] = 1'b1;
        @(negedge sys_clk);
        v[0] = 1'b0;
        total++; if (busy[0] !== 1'b1) $display("FAIL rst_first_edge_accept: got %b want 1", busy[0]); else pass_cnt++;
        run_ticks(0, 10, -1, -1, bits, dones, done_at, gl);
        total++; if (bits[9:0] !== 10'b1_10010110_0) $display("FAIL rst_next_frame: got %b want %b", bits[9:0], 10'b1_10010110_0); else pass_cnt++;
        total++; if (dones !== 1) $display("FAIL rst_next_done_count: got %0d want 1", dones); else pass_cnt++;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0;
            d[k] = 8'h00;
        end
        test_reset();
        test_8n1();
        test_parity_even();
        test_parity_odd_2stop();
        test_back_to_back();
        test_midframe();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
